// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the vector logic pipeline.
//   op_e    - 4-bit microinstruction op codes
//   prec_e  - 2-bit lane precision codes
//   ST_*    - status bit positions inside each lane of the status vector
//   CRU_*   - field positions inside the 7-bit microinstruction word
package logic_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_XOR   = 4'd2,
    OP_NOT   = 4'd3,
    OP_COPY  = 4'd4,
    OP_SEL_GT = 4'd5,
    OP_SEL_EQ = 4'd6,
    OP_SEL_LS = 4'd7,
    OP_LSL   = 4'd8,
    OP_ASL   = 4'd9,
    OP_ROL   = 4'd10,
    OP_LSR   = 4'd11,
    OP_ASR   = 4'd12,
    OP_ROR   = 4'd13,
    OP_FFS1  = 4'd14,
    OP_FFS0  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    PREC_8    = 2'b00,
    PREC_16   = 2'b01,
    PREC_32   = 2'b10,
    PREC_RSVD = 2'b11
  } prec_e;

  // Status bits sit at the base of every lane.
  localparam int ST_LS = 0;
  localparam int ST_EQ = 1;
  localparam int ST_GT = 2;

  localparam int CRU_W     = 7;
  localparam int CRU_VLD   = 6;
  localparam int CRU_OP_HI = 5;
  localparam int CRU_OP_LO = 2;
  localparam int CRU_PR_HI = 1;
  localparam int CRU_PR_LO = 0;

endpackage

// File: rtl/logic_lane.sv
// logic_lane: combinational compute for one lane of width L (8, 16 or 32).
//   s0_i  - source 0 lane
//   s1_i  - source 1 lane; its low log2(L) bits are the shift amount
//   st_i  - lane status bits {GT, EQ, LS}
//   op_i  - operation
//   res_o - lane result
module logic_lane
  import logic_pkg::*;
#(
  parameter int L = 32
) (
  input  logic [L-1:0] s0_i,
  input  logic [L-1:0] s1_i,
  input  logic [2:0]   st_i,
  input  op_e          op_i,
  output logic [L-1:0] res_o
);

  localparam int SH_W = $clog2(L);

  logic [SH_W-1:0] sh;
  logic [2*L-1:0]  rol_w;
  logic [2*L-1:0]  ror_w;
  logic [L-1:0]    asr_w;
  logic [L-1:0]    ffs1;
  logic [L-1:0]    ffs0;

  assign sh = s1_i[SH_W-1:0];

  // Rotates shift a doubled copy so sh=0 never needs an L-bit shift term.
  always_comb begin
    rol_w = {s0_i, s0_i} << sh;
    ror_w = {s0_i, s0_i} >> sh;
    asr_w = $unsigned($signed(s0_i) >>> sh);
  end

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    ffs1 = L'(L);
    ffs0 = L'(L);
    for (int i = L - 1; i >= 0; i--) begin
      if (s0_i[i])  ffs1 = L'(i);
      if (!s0_i[i]) ffs0 = L'(i);
    end
  end

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_AND:    res_o = s0_i & s1_i;
      OP_OR:     res_o = s0_i | s1_i;
      OP_XOR:    res_o = s0_i ^ s1_i;
      OP_NOT:    res_o = ~s0_i;
      OP_COPY:   res_o = s0_i;
      OP_SEL_GT: res_o = st_i[ST_GT] ? s0_i : s1_i;
      OP_SEL_EQ: res_o = st_i[ST_EQ] ? s0_i : s1_i;
      OP_SEL_LS: res_o = st_i[ST_LS] ? s0_i : s1_i;
      OP_LSL,
      OP_ASL:    res_o = s0_i << sh;
      OP_ROL:    res_o = rol_w[2*L-1:L];
      OP_LSR:    res_o = s0_i >> sh;
      OP_ASR:    res_o = asr_w;
      OP_ROR:    res_o = ror_w[L-1:0];
      OP_FFS1:   res_o = ffs1;
      OP_FFS0:   res_o = ffs0;
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_vec_pipe.sv
// logic_vec_pipe: two-stage SIMD logic/shift pipeline with valid/ready flow.
//   clk, rst_n     - clock, async active-low reset
//   dvr_logic_s0   - source 0 vector
//   dvr_logic_s1   - source 1 vector / per-lane shift amounts
//   dvr_logic_st   - per-lane status {GT, EQ, LS} at each lane base
//   cru_logic      - {valid, op[3:0], precision[1:0]}
//   logic_in_rdy   - an instruction can be accepted this cycle
//   dr_logic_d     - result vector
//   dr_logic_vld   - result valid
//   dr_logic_rdy   - consumer takes the result
//   logic_err      - presented result came from reserved precision
// DATA_W must be a multiple of 32 and at least 32.
module logic_vec_pipe
  import logic_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter bit ERR_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dvr_logic_s0,
  input  logic [DATA_W-1:0] dvr_logic_s1,
  input  logic [DATA_W-1:0] dvr_logic_st,
  input  logic [CRU_W-1:0]  cru_logic,
  output logic              logic_in_rdy,
  output logic [DATA_W-1:0] dr_logic_d,
  output logic              dr_logic_vld,
  input  logic              dr_logic_rdy,
  output logic              logic_err
);

  localparam int N8  = DATA_W / 8;
  localparam int N16 = DATA_W / 16;
  localparam int N32 = DATA_W / 32;

  // S1: captured operands and microinstruction
  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_s0_q, s1_s0_d;
  logic [DATA_W-1:0] s1_s1_q, s1_s1_d;
  logic [DATA_W-1:0] s1_st_q, s1_st_d;
  op_e               s1_op_q, s1_op_d;
  prec_e             s1_prec_q, s1_prec_d;

  // S2: computed result
  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] s2_d_q, s2_d_d;
  logic              s2_err_q, s2_err_d;

  logic              s2_adv;
  logic              s1_adv;
  logic              accept;
  logic [DATA_W-1:0] res8, res16, res32;
  logic [DATA_W-1:0] res_sel;
  logic              err_sel;

  assign s2_adv = !s2_vld_q || dr_logic_rdy;
  assign s1_adv = s1_vld_q && s2_adv;
  // Gated by rst_n so the ready output reads 0 while reset is held.
  assign logic_in_rdy = rst_n && (!s1_vld_q || s2_adv);
  assign accept = cru_logic[CRU_VLD] && logic_in_rdy;

  for (genvar g = 0; g < N8; g++) begin : g_lane8
    logic_lane #(.L(8)) u_lane (
      .s0_i  (s1_s0_q[g*8 +: 8]),
      .s1_i  (s1_s1_q[g*8 +: 8]),
      .st_i  (s1_st_q[g*8 +: 3]),
      .op_i  (s1_op_q),
      .res_o (res8[g*8 +: 8])
    );
  end

  for (genvar g = 0; g < N16; g++) begin : g_lane16
    logic_lane #(.L(16)) u_lane (
      .s0_i  (s1_s0_q[g*16 +: 16]),
      .s1_i  (s1_s1_q[g*16 +: 16]),
      .st_i  (s1_st_q[g*16 +: 3]),
      .op_i  (s1_op_q),
      .res_o (res16[g*16 +: 16])
    );
  end

  for (genvar g = 0; g < N32; g++) begin : g_lane32
    logic_lane #(.L(32)) u_lane (
      .s0_i  (s1_s0_q[g*32 +: 32]),
      .s1_i  (s1_s1_q[g*32 +: 32]),
      .st_i  (s1_st_q[g*32 +: 3]),
      .op_i  (s1_op_q),
      .res_o (res32[g*32 +: 32])
    );
  end

  always_comb begin
    res_sel = '0;
    err_sel = 1'b0;
    case (s1_prec_q)
      PREC_8:  res_sel = res8;
      PREC_16: res_sel = res16;
      PREC_32: res_sel = res32;
      default: begin
        err_sel = 1'b1;
        res_sel = ERR_ZERO ? '0 : s1_s0_q;
      end
    endcase
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_s0_d   = s1_s0_q;
    s1_s1_d   = s1_s1_q;
    s1_st_d   = s1_st_q;
    s1_op_d   = s1_op_q;
    s1_prec_d = s1_prec_q;
    s2_vld_d  = s2_vld_q;
    s2_d_d    = s2_d_q;
    s2_err_d  = s2_err_q;

    if (accept) begin
      s1_vld_d  = 1'b1;
      s1_s0_d   = dvr_logic_s0;
      s1_s1_d   = dvr_logic_s1;
      s1_st_d   = dvr_logic_st;
      s1_op_d   = op_e'(cru_logic[CRU_OP_HI:CRU_OP_LO]);
      s1_prec_d = prec_e'(cru_logic[CRU_PR_HI:CRU_PR_LO]);
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      // Data is kept when S2 empties so the bus does not toggle needlessly.
      if (s1_vld_q) begin
        s2_d_d   = res_sel;
        s2_err_d = err_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_s0_q   <= '0;
      s1_s1_q   <= '0;
      s1_st_q   <= '0;
      s1_op_q   <= OP_AND;
      s1_prec_q <= PREC_8;
      s2_vld_q  <= 1'b0;
      s2_d_q    <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_s0_q   <= s1_s0_d;
      s1_s1_q   <= s1_s1_d;
      s1_st_q   <= s1_st_d;
      s1_op_q   <= s1_op_d;
      s1_prec_q <= s1_prec_d;
      s2_vld_q  <= s2_vld_d;
      s2_d_q    <= s2_d_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign dr_logic_vld = s2_vld_q;
  assign dr_logic_d   = s2_d_q;
  assign logic_err    = s2_err_q;

endmodule

// File: tb/tb_logic_vec_pipe.sv
module tb_logic_vec_pipe;

  logic         clk;
  logic         rst_n;
  logic [127:0] dvr_logic_s0;
  logic [127:0] dvr_logic_s1;
  logic [127:0] dvr_logic_st;
  logic [6:0]   cru_logic;
  logic         logic_in_rdy;
  logic [127:0] dr_logic_d;
  logic         dr_logic_vld;
  logic         dr_logic_rdy;
  logic         logic_err;

  int checks = 0;
  int errors = 0;

  logic_vec_pipe #(.DATA_W(128), .ERR_ZERO(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dvr_logic_s0 (dvr_logic_s0),
    .dvr_logic_s1 (dvr_logic_s1),
    .dvr_logic_st (dvr_logic_st),
    .cru_logic    (cru_logic),
    .logic_in_rdy (logic_in_rdy),
    .dr_logic_d   (dr_logic_d),
    .dr_logic_vld (dr_logic_vld),
    .dr_logic_rdy (dr_logic_rdy),
    .logic_err    (logic_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one instruction into an idle pipe and sample the result two edges later.
  // ok reports that valid was low after the first edge and high after the second.
  task automatic run_one(input logic [3:0] op, input logic [1:0] prec,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] st,
                         output logic [127:0] d, output logic e, output bit ok);
    @(negedge clk);
    dvr_logic_s0 = a;
    dvr_logic_s1 = b;
    dvr_logic_st = st;
    dr_logic_rdy = 1'b1;
    cru_logic    = {1'b1, op, prec};
    @(posedge clk);
    #1;
    cru_logic = '0;
    ok = !dr_logic_vld;
    @(posedge clk);
    #1;
    ok = ok && dr_logic_vld;
    d  = dr_logic_d;
    e  = logic_err;
  endtask

  task automatic check_res(input string name, input logic [127:0] d, input logic e,
                           input bit ok, input logic [127:0] exp_d, input logic exp_e);
    checks++;
    if (d !== exp_d || e !== exp_e || !ok) begin
      errors++;
      $display("FAIL %s: got d=%h err=%b lat_ok=%0d, want d=%h err=%b lat_ok=1",
               name, d, e, ok, exp_d, exp_e);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    dvr_logic_s0 = '0;
    dvr_logic_s1 = '0;
    dvr_logic_st = '0;
    cru_logic    = '0;
    dr_logic_rdy = 1'b1;
    #1;
    checks++;
    if ({dr_logic_vld, logic_err, logic_in_rdy} !== 3'b000 || dr_logic_d !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%b err=%b in_rdy=%b d=%h, want all 0",
               dr_logic_vld, logic_err, logic_in_rdy, dr_logic_d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (logic_in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b want 1", logic_in_rdy);
    end
  endtask

  task automatic test_bitwise();
    logic [127:0] d; logic e; bit ok;
    logic [127:0] a, b;
    a = {4{32'h12345678}};
    b = {4{32'h0F0F0F0F}};
    run_one(4'd0, 2'b10, a, b, '0, d, e, ok);
    check_res("and32", d, e, ok, {4{32'h02040608}}, 1'b0);
    run_one(4'd1, 2'b10, a, b, '0, d, e, ok);
    check_res("or32", d, e, ok, {4{32'h1F3F5F7F}}, 1'b0);
    run_one(4'd2, 2'b00, a, b, '0, d, e, ok);
    check_res("xor8", d, e, ok, {4{32'h1D3B5977}}, 1'b0);
    run_one(4'd3, 2'b01, a, b, '0, d, e, ok);
    check_res("not16", d, e, ok, {4{32'hEDCBA987}}, 1'b0);
    run_one(4'd4, 2'b10, a, b, '0, d, e, ok);
    check_res("copy32", d, e, ok, a, 1'b0);
  endtask

  task automatic test_rotate32();
    logic [127:0] d; logic e; bit ok;
    logic [127:0] a;
    a = {4{32'h80000001}};
    run_one(4'd10, 2'b10, a, {32'd0, 32'd1, 32'd0, 32'd1}, '0, d, e, ok);
    check_res("rol32", d, e, ok,
              {32'h80000001, 32'h00000003, 32'h80000001, 32'h00000003}, 1'b0);
    // Only the low 5 bits of s1 are the amount: 0x21 rotates by 1.
    run_one(4'd13, 2'b10, a, {32'h21, 32'd0, 32'd1, 32'd0}, '0, d, e, ok);
    check_res("ror32", d, e, ok,
              {32'hC0000000, 32'h80000001, 32'hC0000000, 32'h80000001}, 1'b0);
  endtask

  task automatic test_shift8();
    logic [127:0] d; logic e; bit ok;
    run_one(4'd12, 2'b00, {16{8'h90}}, {16{8'h03}}, '0, d, e, ok);
    check_res("asr8", d, e, ok, {16{8'hF2}}, 1'b0);
    run_one(4'd11, 2'b00, {16{8'h90}}, {16{8'h03}}, '0, d, e, ok);
    check_res("lsr8", d, e, ok, {16{8'h12}}, 1'b0);
    run_one(4'd14, 2'b00, {4{32'h80010800}}, '0, '0, d, e, ok);
    check_res("ffs1_8", d, e, ok, {4{32'h07000308}}, 1'b0);
    run_one(4'd15, 2'b00, {4{32'hFFFEF7FF}}, '0, '0, d, e, ok);
    check_res("ffs0_8", d, e, ok, {4{32'h08000308}}, 1'b0);
  endtask

  task automatic test_select16();
    logic [127:0] d; logic e; bit ok;
    logic [127:0] a, b;
    a = {8{16'h1234}};
    b = {8{16'hABCD}};
    run_one(4'd5, 2'b01, a, b, {8{16'h0004}}, d, e, ok);
    check_res("selgt_set", d, e, ok, a, 1'b0);
    run_one(4'd5, 2'b01, a, b, '0, d, e, ok);
    check_res("selgt_clr", d, e, ok, b, 1'b0);
    run_one(4'd6, 2'b01, a, b, {4{16'h0002, 16'h0004}}, d, e, ok);
    check_res("seleq_mix", d, e, ok, {4{16'h1234, 16'hABCD}}, 1'b0);
    run_one(4'd7, 2'b01, a, b, {8{16'h0001}}, d, e, ok);
    check_res("sells_set", d, e, ok, a, 1'b0);
    run_one(4'd8, 2'b01, a, {8{16'h0014}}, '0, d, e, ok);
    check_res("lsl16", d, e, ok, {8{16'h2340}}, 1'b0);
    run_one(4'd9, 2'b01, a, {8{16'h0014}}, '0, d, e, ok);
    check_res("asl16", d, e, ok, {8{16'h2340}}, 1'b0);
  endtask

  task automatic test_err();
    logic [127:0] d; logic e; bit ok;
    run_one(4'd4, 2'b11, {4{32'hDEADBEEF}}, '0, '0, d, e, ok);
    check_res("rsvd_prec", d, e, ok, '0, 1'b1);
    run_one(4'd4, 2'b10, {4{32'hDEADBEEF}}, '0, '0, d, e, ok);
    check_res("err_clears", d, e, ok, {4{32'hDEADBEEF}}, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [4];
    logic [3:0]   ops   [4];
    int issued, got;
    bit saw_block, acc;
    exp_q[0] = {4{32'h02040608}}; ops[0] = 4'd0;
    exp_q[1] = {4{32'h1F3F5F7F}}; ops[1] = 4'd1;
    exp_q[2] = {4{32'h1D3B5977}}; ops[2] = 4'd2;
    exp_q[3] = {4{32'hEDCBA987}}; ops[3] = 4'd3;
    issued = 0; got = 0; saw_block = 0;
    @(negedge clk);
    cru_logic = '0;
    dr_logic_rdy = 1'b1;
    repeat (2) @(posedge clk);
    dvr_logic_s0 = {4{32'h12345678}};
    dvr_logic_s1 = {4{32'h0F0F0F0F}};
    dvr_logic_st = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      dr_logic_rdy = (cyc >= 5);
      if (issued < 4) cru_logic = {1'b1, ops[issued], 2'b10};
      else            cru_logic = '0;
      #1;
      if (issued < 4 && !logic_in_rdy) saw_block = 1;
      if (dr_logic_vld) begin
        checks++;
        if (got >= 4) begin
          errors++;
          $display("FAIL b2b_extra: cycle %0d got extra result %h, want none", cyc, dr_logic_d);
        end else begin
          if (dr_logic_d !== exp_q[got]) begin
            errors++;
            $display("FAIL b2b_data: cycle %0d result %0d got %h want %h",
                     cyc, got, dr_logic_d, exp_q[got]);
          end
          if (dr_logic_rdy) got++;
        end
      end
      acc = cru_logic[6] && logic_in_rdy;
      @(posedge clk);
      if (acc) issued++;
    end
    cru_logic = '0;
    checks++;
    if (got != 4 || issued != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results from %0d issued, want 4 and 4", got, issued);
    end
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL b2b_in_rdy: in_rdy never dropped while stalled, want a drop");
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    dr_logic_rdy = 1'b0;
    dvr_logic_s0 = {4{32'h11111111}};
    cru_logic    = {1'b1, 4'd4, 2'b11};
    @(posedge clk);
    @(negedge clk);
    cru_logic = {1'b1, 4'd4, 2'b10};
    @(posedge clk);
    @(negedge clk);
    cru_logic = '0;
    #1;
    checks++;
    if (dr_logic_vld !== 1'b1 || logic_in_rdy !== 1'b0 || logic_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: got vld=%b in_rdy=%b err=%b, want 1 0 1",
               dr_logic_vld, logic_in_rdy, logic_err);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dr_logic_vld !== 1'b0 || logic_err !== 1'b0 || dr_logic_d !== '0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b err=%b d=%h, want 0 0 0",
               dr_logic_vld, logic_err, dr_logic_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dr_logic_rdy = 1'b1;
    #1;
    checks++;
    if (logic_in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_rdy: got %b want 1", logic_in_rdy);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dr_logic_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: got vld=%b want 0", dr_logic_vld);
    end
  endtask

  initial begin
    test_reset();
    test_bitwise();
    test_rotate32();
    test_shift8();
    test_select16();
    test_err();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_vec_pipe.md
LOGIC_VEC_PIPE -- requirements
Module: logic_vec_pipe

Interface
REQ-001 Parameter DATA_W, default 128, meaning vector width in bits; it SHALL be a multiple of 32 and at least 32.
REQ-002 Parameter ERR_ZERO, default 1, meaning reserved-precision results are forced to zero when 1 and pass s0 through unchanged when 0.
REQ-003 Port clk, input, 1 bit: the single clock for the block.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port dvr_logic_s0, input, DATA_W bits: source 0 vector.
REQ-006 Port dvr_logic_s1, input, DATA_W bits: source 1 vector, also the per-lane shift amount.
REQ-007 Port dvr_logic_st, input, DATA_W bits: status vector; each lane's bits [2:0] at the lane base are GT, EQ, LS.
REQ-008 Port cru_logic, input, 7 bits: [6] valid, [5:2] op, [1:0] precision (00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = reserved).
REQ-009 Port logic_in_rdy, output, 1 bit: the block can accept a microinstruction.
REQ-010 Port dr_logic_d, output, DATA_W bits: result vector.
REQ-011 Port dr_logic_vld, output, 1 bit: dr_logic_d is valid.
REQ-012 Port dr_logic_rdy, input, 1 bit: the consumer accepts the result.
REQ-013 Port logic_err, output, 1 bit: the result currently presented came from reserved precision 11.

Function
REQ-014 An instruction SHALL be accepted on a rising clk edge where cru_logic[6] and logic_in_rdy are both 1.
REQ-015 The pipeline SHALL have two register stages: S1 captures operands and the microinstruction, S2 holds the computed result; latency from acceptance to dr_logic_vld SHALL be 2 cycles.
REQ-016 A stage SHALL advance when the stage after it is empty or is being drained in the same cycle; logic_in_rdy = !S1_vld || S1 advances.
REQ-017 dr_logic_d and logic_err SHALL hold stable while dr_logic_vld=1 and dr_logic_rdy=0; no accepted instruction SHALL be dropped or duplicated.
REQ-018 With dr_logic_rdy held at 1, the block SHALL sustain one instruction per cycle.
REQ-019 Lane width L SHALL be 8, 16 or 32 bits, giving DATA_W/L independent lanes.
REQ-020 Ops 0-4 SHALL be AND, OR, XOR, NOT s0, and COPY s0.
REQ-021 Ops 5, 6 and 7 SHALL select s0 when the lane's GT, EQ or LS bit respectively is 1, and s1 otherwise.
REQ-022 Shift amount sh SHALL be s1 lane bits [log2(L)-1:0].
REQ-023 Op 8 (LSL) and op 9 (ASL) SHALL both produce s0<<sh with zero fill.
REQ-024 Op 11 (LSR) SHALL zero-fill; op 12 (ASR) SHALL fill with the lane sign bit.
REQ-025 Op 10 SHALL rotate left ((x<<sh)|(x>>(L-sh))) and op 13 SHALL rotate right; sh=0 SHALL return x unchanged with no out-of-range term.
REQ-026 Op 14 SHALL return the index of the least-significant 1 in s0, zero-extended to L bits, or L when no 1 is present.
REQ-027 Op 15 SHALL return the index of the least-significant 0 in s0, zero-extended to L bits, or L when no 0 is present.
REQ-028 Precision 11 SHALL set logic_err with the result, and the data SHALL follow ERR_ZERO.
REQ-029 All outputs SHALL reset to 0.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously clear both stage valid bits, dr_logic_d and logic_err, at any time including mid-operation; in-flight instructions are discarded.
REQ-031 logic_in_rdy SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Op codes, precision codes and status bit positions SHALL live in the shared package logic_pkg.
REQ-033 Per-lane compute SHALL be one sub-module, logic_lane (parameter L), instantiated per lane for each supported width; the top level muxes the results by precision.

Verification
REQ-034 Precision 10, op 10, s0 lane = 0x80000001, sh=1 -> lane 0x00000003; sh=0 -> 0x80000001.
REQ-035 Precision 00, op 12, s0 byte = 0x90, sh=3 -> 0xF2; op 14 on 0x00 -> 0x08; op 15 on 0xFF -> 0x08.
REQ-036 Precision 01, op 5, st lane bits = 3'b100, s0=0x1234, s1=0xABCD -> 0x1234; same operands with st=3'b000 -> 0xABCD.
REQ-037 Issue 4 back-to-back instructions, hold dr_logic_rdy=0 for 3 cycles and then release -> in_rdy falls once both stages are full, results emerge in order and unchanged while stalled, and none is lost.
REQ-038 Precision 11 with ERR_ZERO=1 -> dr_logic_d=0 and logic_err=1 two cycles after acceptance.
REQ-039 Assert rst_n low while both stages are full -> dr_logic_vld=0 immediately, and in_rdy=1 in the cycle after rst_n releases.
